// File: rtl/shift_add_multiplier.sv
`timescale 1ns/1ps
// shift_add_multiplier
//   Iterative unsigned multiplier. A start pulse captures a and b. The block
//   then runs WIDTH add-and-shift iterations and writes the 2*WIDTH-bit
//   product. A start/busy/done handshake controls the exchange.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears all state
//   start    request; accepted only in IDLE or DONE
//   a        multiplicand (unsigned, WIDTH bits), captured on the accepting edge
//   b        multiplier   (unsigned, WIDTH bits), captured on the accepting edge
//   busy     high while iterating
//   done     one-cycle completion pulse
//   product  last completed a*b (2*WIDTH bits); held until the next completion
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc_nx;

  // One iteration. The upper half of the accumulator goes through the
  // WIDTH-bit adder when the current multiplier bit is set. The adder carry
  // becomes the new MSB as the whole word shifts right by one.
  function automatic logic [2*WIDTH-1:0] step(
    input logic [2*WIDTH-1:0] acc_v,
    input logic [WIDTH-1:0]   m
  );
    logic [WIDTH:0] s;
    if (acc_v[0])
      s = {1'b0, acc_v[2*WIDTH-1:WIDTH]} + {1'b0, m};
    else
      s = {1'b0, acc_v[2*WIDTH-1:WIDTH]};
    return {s, acc_v[WIDTH-1:1]};
  endfunction

  assign acc_nx = step(acc, mcand_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand_r <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand_r <= a;
            acc     <= {{WIDTH{1'b0}}, b};
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored here: the operands are not re-sampled.
          acc   <= acc_nx;
          count <= count + 1'b1;
          if (count == LAST) begin
            product <= acc_nx;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
`timescale 1ns/1ps
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Run one WIDTH=8 operation. Returns the product, the number of edges from
  // acceptance to done, and whether busy ever dropped or overlapped done.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, output logic [15:0] p,
                     output int lat, output bit glitch);
    @(negedge clk);
    a8 = ta; b8 = tb_; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; glitch = 1'b0;
    while (!done8 && lat < 40) begin
      if (!busy8) glitch = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (busy8) glitch = 1'b1;
    p = product8;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, output logic [7:0] p,
                     output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb_; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = product4;
  endtask

  task automatic count_dones8(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done8) n++;
    end
  endtask

  initial begin
    vec_t        tbl[6];
    logic [15:0] p;
    logic [7:0]  p4;
    logic [7:0]  ra, rb;
    logic [3:0]  ra4, rb4;
    int          lat, n, bad_p, bad_l;
    bit          glitch;

    tbl[0] = '{a: 8'd3,   b: 8'd5,   p: 16'h000F};
    tbl[1] = '{a: 8'hFF,  b: 8'hFF,  p: 16'hFE01};
    tbl[2] = '{a: 8'h80,  b: 8'h02,  p: 16'h0100};
    tbl[3] = '{a: 8'h00,  b: 8'hAB,  p: 16'h0000};
    tbl[4] = '{a: 8'hAB,  b: 8'h01,  p: 16'h00AB};
    tbl[5] = '{a: 8'h01,  b: 8'hFF,  p: 16'h00FF};

    // reset state, checked asynchronously before any clock edge matters
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_product8", 32'(product8), 0);
    check("rst_product4", 32'(product4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed table
    foreach (tbl[i]) begin
      op8(tbl[i].a, tbl[i].b, p, lat, glitch);
      check($sformatf("tbl%0d_product", i), 32'(p), 32'(tbl[i].p));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 8);
      check($sformatf("tbl%0d_busy", i), 32'(glitch), 0);
      if (i == 0) begin
        @(negedge clk);
        check("done_one_cycle", 32'(done8), 0);
        repeat (9) @(negedge clk);
        check("product_hold", 32'(product8), 16'h000F);
      end
    end

    // start while busy: the second request must vanish without trace
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; glitch = 1'b0;
    while (!done8 && lat < 40) begin
      if (!busy8) glitch = 1'b1;
      if (lat == 3) begin a8 = 8'd9; b8 = 8'd9; start8 = 1'b1; end
      else start8 = 1'b0;
      if (lat == 2) check("hold_while_busy", 32'(product8), 16'h00FF);
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    check("swb_product", 32'(product8), 6);
    check("swb_latency", 32'(lat), 8);
    check("swb_busy", 32'(glitch), 0);
    check("swb_overlap", 32'(busy8 & done8), 0);
    count_dones8(12, n);
    check("swb_extra_done", 32'(n), 0);

    // back-to-back: start held through DONE
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd6;
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_first", 32'(product8), 25);
    lat = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
    end while (!done8 && lat < 40);
    check("b2b_second", 32'(product8), 42);
    check("b2b_spacing", 32'(lat), 9);

    // reset mid-run
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_product", 32'(product8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones8(12, n);
    check("abort_no_done", 32'(n), 0);
    op8(8'd4, 8'd4, p, lat, glitch);
    check("post_rst_product", 32'(p), 16);
    check("post_rst_latency", 32'(lat), 8);

    // WIDTH=4
    op4(4'hF, 4'hF, p4, lat);
    check("w4_product", 32'(p4), 8'hE1);
    check("w4_latency", 32'(lat), 4);

    // random sweeps against plain multiplication; one summary compare each
    bad_p = 0; bad_l = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb, p, lat, glitch);
      if (p !== 16'(ra) * 16'(rb)) begin
        bad_p++;
        if (bad_p <= 5) $display("FAIL rand8 %0d*%0d: got %0d expected %0d", ra, rb, p, 16'(ra) * 16'(rb));
      end
      if (lat != 8 || glitch) bad_l++;
    end
    check("rand8_product_errors", 32'(bad_p), 0);
    check("rand8_latency_errors", 32'(bad_l), 0);

    bad_p = 0; bad_l = 0;
    for (int i = 0; i < 300; i++) begin
      ra4 = 4'($urandom); rb4 = 4'($urandom);
      op4(ra4, rb4, p4, lat);
      if (p4 !== 8'(ra4) * 8'(rb4)) bad_p++;
      if (lat != 4) bad_l++;
    end
    check("rand4_product_errors", 32'(bad_p), 0);
    check("rand4_latency_errors", 32'(bad_l), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
